pid_input_scheduler: RTL and testbench
======================================

Name: pid_input_scheduler

Overview:
Shares the single PID processing pipeline between N_CHAN independent ADC sample sources.
- Each source has a one-deep holding register.
- A round-robin scheduler issues one held sample at a time into the pipeline's dv/src/data input, enforcing a programmable minimum issue gap so the multicycle pipeline stages are never over-driven.
- Sits between the ADC front-end controllers and the PID pipeline. Sticky per-channel overrun flags are reported to the host.

Parameters:
N_CHAN, 5, number of source channels (≥2)
W_CHAN, 8, channel index width on output
W_DATA, 18, sample width (signed)
W_WR_ADDR, 16, host write address width
W_WR_DATA, 48, host write data width
W_GAP, 8, issue-gap register width
GAP_DEFAULT, 3, reset value of gap register
ADDR_GAP, 16'h0040, host address of gap register
ADDR_OVR_CLR, 16'h0041, host address of overrun-clear strobe

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; asynchronous, active-high
dv_in  in  N_CHAN  per-source one-cycle sample-valid pulse
data_in  in  N_CHAN*W_DATA  packed samples; source i at [i*W_DATA +: W_DATA]
chan_en_in  in  N_CHAN  per-channel enable from instruction dispatch
wr_en  in  1  host write strobe
wr_addr  in  W_WR_ADDR  host write address
wr_data  in  W_WR_DATA  host write data
dv_out  out  1  one-cycle pulse; sample issued to pipeline
chan_out  out  W_CHAN  source index of issued sample, zero-extended
data_out  out  W_DATA  issued sample (signed)
ovr_out  out  N_CHAN  sticky overrun flags

Behaviour:
- Reset is asynchronous and active-high. It clears the following: dv_out, chan_out, data_out, ovr_out, all pend bits and hold registers, and cnt.
- Reset sets gap_reg=GAP_DEFAULT and last=N_CHAN-1, so channel 0 wins first.
- Capture (edge k): dv_in[i]&chan_en_in[i] loads hold[i] from data_in slice i and sets pend[i].
- Capture while pend[i]=1 and channel i is not granted in the same cycle: hold[i] is overwritten (newest sample kept) and ovr_out[i] is set.
- Grant and capture of the same channel in the same cycle: the old hold[i] is issued, the new sample is captured, pend[i] stays 1, and no overrun is flagged.
- chan_en_in[i]=0 clears pend[i] and ignores dv_in[i]; ovr_out[i] is retained.
- Scheduler FSM, evaluated every edge:
  - IDLE: no pend bits set. dv_out=0.
  - ISSUE: entered when cnt==0 and any pend bit is set.
    - Selects the first pending index searching upward from (last+1) mod N_CHAN, wrapping.
    - Registers dv_out=1, chan_out=i, data_out=hold[i]. Clears pend[i], sets last=i, loads cnt=gap_reg.
  - HOLDOFF: cnt>0. dv_out=0 and cnt decrements by 1. Pending captures wait.
- Transitions out of ISSUE: to HOLDOFF if gap_reg>0; otherwise back to ISSUE (if pending) or IDLE.
- Latency: a sample captured at edge k drives dv_out high after edge k+1 at the earliest.
- Issue spacing: successive dv_out pulses are ≥gap_reg+1 cycles apart. gap_reg=0 allows one issue per cycle.
- chan_out and data_out hold their last value while dv_out=0.
- Host interface (wr_en=1):
  - wr_addr==ADDR_GAP: gap_reg<=wr_data[W_GAP-1:0]. Takes effect at the next cnt load; an in-progress HOLDOFF is not modified.
  - wr_addr==ADDR_OVR_CLR: ovr_out <= ovr_out & ~wr_data[N_CHAN-1:0]. If an overrun occurs in the same cycle as its clear, the set wins.
  - Other addresses are ignored.
- Fairness: with all channels continuously pending, issue order is 0,1,…,N_CHAN-1,0,… The worst-case wait for any pending channel is N_CHAN*(gap_reg+1) cycles.

Test Plan:
1. Reset, gap_reg=3. Pulse dv_in[2] with data 18'h00123 at edge 10 -> dv_out high after edge 11, chan_out=2, data_out=18'h00123. No further dv_out. ovr_out=0.
2. gap=0. Pulse all 5 dv_in in the same cycle with data i*100 -> 5 consecutive dv_out cycles, chan_out 0,1,2,3,4 carrying data 0,100,200,300,400.
3. gap=3. Pulse dv_in[0] and dv_in[1] together -> dv_out pulses exactly 4 cycles apart, channel 0 first. Rewrite gap=1 during HOLDOFF -> current 4-cycle spacing is kept; the next spacing is 2 cycles.
4. Hold ch1 pending behind a long gap. Pulse dv_in[1] twice with data -5 then 7 -> ovr_out[1]=1 and the issued data is 7. Write ADDR_OVR_CLR with data 2 -> ovr_out[1]=0 on the next cycle.
5. Set chan_en_in[3]=0 while ch3 is pending -> ch3 is never issued and subsequent dv_in[3] is ignored. Re-enable -> a new pulse issues normally.
6. Assert rst_in asynchronously mid-HOLDOFF with 3 channels pending -> all outputs are 0 immediately and pend is cleared. After release, gap_reg=3 and the first new issue goes to the lowest pending channel.

Source files
------------

// File: rtl/pid_input_scheduler.sv
// pid_input_scheduler
// Shares one PID pipeline input between N_CHAN ADC sample sources. Each source
// owns a one-deep holding register; a round-robin scheduler issues one held
// sample at a time and enforces a programmable minimum gap between issues.
//
// Ports:
//   clk_in, rst_in   clock, asynchronous active-high reset
//   dv_in            per-source one-cycle sample-valid pulse
//   data_in          packed samples, source i at [i*W_DATA +: W_DATA]
//   chan_en_in       per-channel enable; low drops any pending sample
//   wr_en/addr/data  host register write port (gap register, overrun clear)
//   dv_out           one-cycle pulse, sample issued to pipeline
//   chan_out         source index of issued sample (zero-extended)
//   data_out         issued sample (signed)
//   ovr_out          sticky per-channel overrun flags
module pid_input_scheduler #(
  parameter int unsigned N_CHAN      = 5,
  parameter int unsigned W_CHAN      = 8,
  parameter int unsigned W_DATA      = 18,
  parameter int unsigned W_WR_ADDR   = 16,
  parameter int unsigned W_WR_DATA   = 48,
  parameter int unsigned W_GAP       = 8,
  parameter int unsigned GAP_DEFAULT = 3,
  parameter logic [W_WR_ADDR-1:0] ADDR_GAP     = 16'h0040,
  parameter logic [W_WR_ADDR-1:0] ADDR_OVR_CLR = 16'h0041
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_CHAN-1:0]          dv_in,
  input  logic [N_CHAN*W_DATA-1:0]   data_in,
  input  logic [N_CHAN-1:0]          chan_en_in,
  input  logic                       wr_en,
  input  logic [W_WR_ADDR-1:0]       wr_addr,
  input  logic [W_WR_DATA-1:0]       wr_data,
  output logic                       dv_out,
  output logic [W_CHAN-1:0]          chan_out,
  output logic signed [W_DATA-1:0]   data_out,
  output logic [N_CHAN-1:0]          ovr_out
);

  localparam int unsigned W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [W_GAP-1:0]          cnt_q, cnt_d;
  logic [W_GAP-1:0]          gap_q, gap_d;
  logic [W_IDX-1:0]          last_q;
  logic [N_CHAN-1:0]         pend_q, pend_d;
  logic signed [W_DATA-1:0]  hold_q [N_CHAN];

  logic [N_CHAN-1:0]         cap_c;
  logic [N_CHAN-1:0]         elig_c;
  logic                      any_elig_c;
  logic [W_IDX-1:0]          rr_idx;
  logic [W_IDX-1:0]          hi_idx;
  logic [W_IDX-1:0]          lo_idx;
  logic                      hi_found;
  logic                      issue_c;
  logic [N_CHAN-1:0]         grant_vec;
  logic signed [W_DATA-1:0]  issue_data;
  logic [N_CHAN-1:0]         ovr_set;
  logic [N_CHAN-1:0]         ovr_clr;
  logic [N_CHAN-1:0]         ovr_d;
  logic                      unused_wr_bits;

  // Only the low gap / channel-mask bits of host write data are meaningful.
  assign unused_wr_bits = ^wr_data;

  // A disabled channel neither captures nor competes for the pipeline.
  assign cap_c      = dv_in & chan_en_in;
  assign elig_c     = pend_q & chan_en_in;
  assign any_elig_c = |elig_c;

  // Round-robin pick: lowest eligible index above last, else lowest overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = int'(N_CHAN) - 1; c >= 0; c--) begin
      if (elig_c[c]) begin
        lo_idx = W_IDX'(c);
        if (W_IDX'(c) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = W_IDX'(c);
        end
      end
    end
    rr_idx = hi_found ? hi_idx : lo_idx;
  end

  // Scheduler state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scheduler next state: the holdoff counter gates issue; cnt==1 is the last holdoff cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        state_d = any_elig_c ? S_ISSUE : S_IDLE;
      end
      S_ISSUE, S_HOLDOFF: begin
        if (cnt_q > W_GAP'(1)) begin
          state_d = S_HOLDOFF;
        end else if (cnt_q == W_GAP'(1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = any_elig_c ? S_ISSUE : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scheduler outputs: issue strobe, grant mask, counter and bookkeeping next values.
  always_comb begin
    issue_c    = (state_d == S_ISSUE);
    grant_vec  = '0;
    issue_data = '0;
    for (int unsigned c = 0; c < N_CHAN; c++) begin
      grant_vec[c] = issue_c && (rr_idx == W_IDX'(c));
      if (rr_idx == W_IDX'(c)) begin
        issue_data = hold_q[c];
      end
    end

    if (issue_c) begin
      cnt_d = gap_q;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W_GAP'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Same-cycle grant and capture hands off the old sample and keeps the new one pending.
    pend_d = chan_en_in & (cap_c | (pend_q & ~grant_vec));

    // Overrun only when a pending sample is replaced without being issued; set beats clear.
    ovr_set = cap_c & pend_q & ~grant_vec;
    ovr_clr = (wr_en && (wr_addr == ADDR_OVR_CLR)) ? wr_data[N_CHAN-1:0] : '0;
    ovr_d   = (ovr_out & ~ovr_clr) | ovr_set;

    // New gap is picked up at the next counter load; a running holdoff is untouched.
    gap_d = (wr_en && (wr_addr == ADDR_GAP)) ? wr_data[W_GAP-1:0] : gap_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      gap_q    <= W_GAP'(GAP_DEFAULT);
      last_q   <= W_IDX'(N_CHAN - 1);
      pend_q   <= '0;
      ovr_out  <= '0;
      dv_out   <= 1'b0;
      chan_out <= '0;
      data_out <= '0;
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovr_out <= ovr_d;
      dv_out  <= issue_c;
      if (issue_c) begin
        chan_out <= W_CHAN'(rr_idx);
        data_out <= issue_data;
        last_q   <= rr_idx;
      end
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        if (cap_c[i]) begin
          hold_q[i] <= data_in[i*W_DATA +: W_DATA];
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_input_scheduler.sv
// Self-checking bench for pid_input_scheduler: directed scenarios plus a
// randomized run against a cycle-count based reference model.
module tb_pid_input_scheduler;

  localparam int N = 5;
  localparam int W = 18;
  localparam logic [15:0] A_GAP = 16'h0040;
  localparam logic [15:0] A_CLR = 16'h0041;

  logic                    clk_in;
  logic                    rst_in;
  logic [N-1:0]            dv_in;
  logic [N*W-1:0]          data_in;
  logic [N-1:0]            chan_en_in;
  logic                    wr_en;
  logic [15:0]             wr_addr;
  logic [47:0]             wr_data;
  logic                    dv_out;
  logic [7:0]              chan_out;
  logic signed [W-1:0]     data_out;
  logic [N-1:0]            ovr_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0]   m_pend;
  logic [W-1:0]   m_hold [N];
  int             m_last;
  int             m_gap;
  int             m_cyc;
  int             m_next_ok;
  logic [N-1:0]   m_ovr;
  logic           exp_dv;
  int             exp_chan;
  logic [W-1:0]   exp_data;

  pid_input_scheduler dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .dv_in      (dv_in),
    .data_in    (data_in),
    .chan_en_in (chan_en_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dv_out     (dv_out),
    .chan_out   (chan_out),
    .data_out   (data_out),
    .ovr_out    (ovr_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pend    = '0;
    for (int i = 0; i < N; i++) m_hold[i] = '0;
    m_last    = N - 1;
    m_gap     = 3;
    m_ovr     = '0;
    m_next_ok = m_cyc;
    exp_dv    = 1'b0;
    exp_chan  = 0;
    exp_data  = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs currently driven.
  task automatic model_edge();
    logic [N-1:0] cap;
    logic [N-1:0] elig;
    int g;
    cap  = dv_in & chan_en_in;
    elig = m_pend & chan_en_in;
    g = -1;
    if (elig != '0 && m_cyc >= m_next_ok) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (g < 0 && elig[j]) g = j;
      end
    end
    exp_dv = (g >= 0);
    if (g >= 0) begin
      exp_chan  = g;
      exp_data  = m_hold[g];
      m_last    = g;
      m_next_ok = m_cyc + m_gap + 1;
    end
    if (wr_en && wr_addr == A_CLR) m_ovr = m_ovr & ~wr_data[N-1:0];
    for (int i = 0; i < N; i++) begin
      if (!chan_en_in[i]) begin
        m_pend[i] = 1'b0;
      end else if (cap[i]) begin
        if (m_pend[i] && g != i) m_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
        m_hold[i] = data_in[i*W +: W];
      end else if (g == i) begin
        m_pend[i] = 1'b0;
      end
    end
    if (wr_en && wr_addr == A_GAP) m_gap = int'(wr_data[7:0]);
    m_cyc++;
  endtask

  // Advance one clock; pulse inputs are dropped right after the edge.
  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
    dv_in   = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic host_write(input logic [15:0] addr, input logic [47:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
  endtask

  task automatic do_reset();
    rst_in  = 1'b1;
    dv_in   = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chan_en_in = '1;
  endtask

  task automatic test_reset();
    data_in = '0;
    m_cyc = 0;
    do_reset();
    checks++;
    if (dv_out !== 1'b0 || chan_out !== 8'd0 || data_out !== 18'sd0 || ovr_out !== 5'd0)
      begin errors++; $display("FAIL reset_outputs: dv=%0b chan=%0d data=%h ovr=%b, expected all zero", dv_out, chan_out, data_out, ovr_out); end
  endtask

  task automatic test_single();
    do_reset();
    repeat (3) tick();
    dv_in[2] = 1'b1;
    data_in[2*W +: W] = 18'h00123;
    tick();
    checks++;
    if (dv_out !== 1'b0) begin errors++; $display("FAIL single_capture_edge: dv=%0b expected 0", dv_out); end
    tick();
    checks++;
    if (dv_out !== 1'b1 || chan_out !== 8'd2 || data_out !== 18'sh00123)
      begin errors++; $display("FAIL single_issue: dv=%0b chan=%0d data=%h, expected dv=1 chan=2 data=00123", dv_out, chan_out, data_out); end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (dv_out !== 1'b0 || ovr_out !== 5'd0)
        begin errors++; $display("FAIL single_quiet: cycle %0d dv=%0b ovr=%b, expected dv=0 ovr=0", c, dv_out, ovr_out); end
    end
    checks++;
    if (chan_out !== 8'd2 || data_out !== 18'sh00123)
      begin errors++; $display("FAIL single_hold: chan=%0d data=%h, expected chan=2 data=00123", chan_out, data_out); end
  endtask

  task automatic test_gap0();
    logic [W-1:0] e;
    do_reset();
    host_write(A_GAP, 48'd0);
    for (int i = 0; i < N; i++) begin
      dv_in[i] = 1'b1;
      data_in[i*W +: W] = 18'(i * 100);
    end
    tick();
    for (int i = 0; i < N; i++) begin
      tick();
      e = 18'(i * 100);
      checks++;
      if (dv_out !== 1'b1 || chan_out !== 8'(i) || data_out !== e)
        begin errors++; $display("FAIL gap0_issue: slot %0d dv=%0b chan=%0d data=%0d, expected dv=1 chan=%0d data=%0d", i, dv_out, chan_out, data_out, i, e); end
    end
    tick();
    checks++;
    if (dv_out !== 1'b0) begin errors++; $display("FAIL gap0_drain: dv=%0b expected 0", dv_out); end
  endtask

  task automatic test_gap_rewrite();
    logic [5:0] dv_seq;
    do_reset();
    dv_in[0] = 1'b1; data_in[0*W +: W] = 18'd11;
    dv_in[1] = 1'b1; data_in[1*W +: W] = 18'd22;
    tick();
    tick();
    checks++;
    if (dv_out !== 1'b1 || chan_out !== 8'd0 || data_out !== 18'sd11)
      begin errors++; $display("FAIL gap_first: dv=%0b chan=%0d data=%0d, expected dv=1 chan=0 data=11", dv_out, chan_out, data_out); end
    dv_in[0] = 1'b1; data_in[0*W +: W] = 18'd33;
    host_write(A_GAP, 48'd1);
    dv_seq[0] = dv_out;
    tick(); dv_seq[1] = dv_out;
    tick(); dv_seq[2] = dv_out;
    checks++;
    if (dv_seq[2:0] !== 3'b000) begin errors++; $display("FAIL gap_holdoff: dv over 3 cycles=%b expected 000", dv_seq[2:0]); end
    tick();
    checks++;
    if (dv_out !== 1'b1 || chan_out !== 8'd1 || data_out !== 18'sd22)
      begin errors++; $display("FAIL gap_second: dv=%0b chan=%0d data=%0d, expected dv=1 chan=1 data=22", dv_out, chan_out, data_out); end
    tick();
    checks++;
    if (dv_out !== 1'b0) begin errors++; $display("FAIL gap_new_holdoff: dv=%0b expected 0", dv_out); end
    tick();
    checks++;
    if (dv_out !== 1'b1 || chan_out !== 8'd0 || data_out !== 18'sd33)
      begin errors++; $display("FAIL gap_third: dv=%0b chan=%0d data=%0d, expected dv=1 chan=0 data=33", dv_out, chan_out, data_out); end
    tick();
    checks++;
    if (dv_out !== 1'b0 || ovr_out !== 5'd0)
      begin errors++; $display("FAIL gap_end: dv=%0b ovr=%b, expected dv=0 ovr=0", dv_out, ovr_out); end
  endtask

  task automatic test_overrun();
    bit found;
    do_reset();
    host_write(A_GAP, 48'd20);
    dv_in[0] = 1'b1; data_in[0*W +: W] = 18'd1;
    tick();
    tick();
    dv_in[1] = 1'b1; data_in[1*W +: W] = 18'(-5);
    tick();
    dv_in[1] = 1'b1; data_in[1*W +: W] = 18'd7;
    tick();
    checks++;
    if (ovr_out !== 5'b00010) begin errors++; $display("FAIL ovr_set: ovr=%b expected 00010", ovr_out); end
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (dv_out === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL ovr_issue_timeout: no dv_out within 40 cycles, expected issue of ch1");
    end else if (chan_out !== 8'd1 || data_out !== 18'sd7) begin
      errors++; $display("FAIL ovr_issue: chan=%0d data=%0d, expected chan=1 data=7", chan_out, data_out);
    end
    host_write(A_CLR, 48'd2);
    checks++;
    if (ovr_out !== 5'd0) begin errors++; $display("FAIL ovr_clear: ovr=%b expected 00000", ovr_out); end
    dv_in[1] = 1'b1; data_in[1*W +: W] = 18'(-1);
    tick();
    dv_in[1] = 1'b1; data_in[1*W +: W] = 18'd9;
    host_write(A_CLR, 48'd2);
    checks++;
    if (ovr_out !== 5'b00010) begin errors++; $display("FAIL ovr_set_beats_clear: ovr=%b expected 00010", ovr_out); end
    host_write(A_CLR, 48'h1F);
    checks++;
    if (ovr_out !== 5'd0) begin errors++; $display("FAIL ovr_clear2: ovr=%b expected 00000", ovr_out); end
  endtask

  task automatic test_disable();
    do_reset();
    host_write(A_GAP, 48'd10);
    dv_in[0] = 1'b1; data_in[0*W +: W] = 18'd5;
    tick();
    tick();
    dv_in[3] = 1'b1; data_in[3*W +: W] = 18'h00333;
    tick();
    chan_en_in[3] = 1'b0;
    tick();
    dv_in[3] = 1'b1; data_in[3*W +: W] = 18'h001FF;
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (dv_out !== 1'b0) begin errors++; $display("FAIL disable_no_issue: cycle %0d dv=%0b chan=%0d expected dv=0", c, dv_out, chan_out); end
    end
    chan_en_in[3] = 1'b1;
    tick();
    dv_in[3] = 1'b1; data_in[3*W +: W] = 18'h003AB;
    tick();
    tick();
    checks++;
    if (dv_out !== 1'b1 || chan_out !== 8'd3 || data_out !== 18'sh003AB || ovr_out !== 5'd0)
      begin errors++; $display("FAIL disable_reenable: dv=%0b chan=%0d data=%h ovr=%b, expected dv=1 chan=3 data=003ab ovr=0", dv_out, chan_out, data_out, ovr_out); end
  endtask

  task automatic test_async_reset();
    logic [3:0] quiet;
    do_reset();
    dv_in[4] = 1'b1; data_in[4*W +: W] = 18'd44;
    tick();
    tick();
    dv_in[1] = 1'b1; data_in[1*W +: W] = 18'd1;
    dv_in[2] = 1'b1; data_in[2*W +: W] = 18'h00020;
    dv_in[3] = 1'b1; data_in[3*W +: W] = 18'h00030;
    tick();
    dv_in[1] = 1'b1; data_in[1*W +: W] = 18'd5;
    tick();
    checks++;
    if (chan_out !== 8'd4 || ovr_out !== 5'b00010)
      begin errors++; $display("FAIL arst_pre: chan=%0d ovr=%b, expected chan=4 ovr=00010", chan_out, ovr_out); end
    #2;
    rst_in = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dv_out !== 1'b0 || chan_out !== 8'd0 || data_out !== 18'sd0 || ovr_out !== 5'd0)
      begin errors++; $display("FAIL arst_immediate: dv=%0b chan=%0d data=%h ovr=%b, expected all zero", dv_out, chan_out, data_out, ovr_out); end
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      quiet[c] = dv_out;
    end
    checks++;
    if (quiet !== 4'b0000) begin errors++; $display("FAIL arst_pend_cleared: dv over 4 cycles=%b expected 0000", quiet); end
    dv_in[3] = 1'b1; data_in[3*W +: W] = 18'h00030;
    dv_in[2] = 1'b1; data_in[2*W +: W] = 18'h00020;
    tick();
    tick();
    checks++;
    if (dv_out !== 1'b1 || chan_out !== 8'd2 || data_out !== 18'sh00020)
      begin errors++; $display("FAIL arst_first: dv=%0b chan=%0d data=%h, expected dv=1 chan=2 data=00020", dv_out, chan_out, data_out); end
    for (int c = 0; c < 3; c++) begin
      tick();
      quiet[c] = dv_out;
    end
    checks++;
    if (quiet[2:0] !== 3'b000) begin errors++; $display("FAIL arst_gap_default: dv over 3 cycles=%b expected 000", quiet[2:0]); end
    tick();
    checks++;
    if (dv_out !== 1'b1 || chan_out !== 8'd3 || data_out !== 18'sh00030)
      begin errors++; $display("FAIL arst_second: dv=%0b chan=%0d data=%h, expected dv=1 chan=3 data=00030", dv_out, chan_out, data_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    host_write(A_GAP, 48'd0);
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) begin
        dv_in[0] = 1'b1;
        data_in[0*W +: W] = 18'(v);
      end
      tick();
      checks++;
      if (v == 1) begin
        if (dv_out !== 1'b0) begin errors++; $display("FAIL b2b_capture: dv=%0b expected 0", dv_out); end
      end else if (dv_out !== 1'b1 || chan_out !== 8'd0 || data_out !== 18'(v - 1)) begin
        errors++; $display("FAIL b2b_issue: step %0d dv=%0b chan=%0d data=%0d, expected dv=1 chan=0 data=%0d", v, dv_out, chan_out, data_out, v - 1);
      end
    end
    tick();
    checks++;
    if (dv_out !== 1'b0 || ovr_out !== 5'd0)
      begin errors++; $display("FAIL b2b_end: dv=%0b ovr=%b, expected dv=0 ovr=0", dv_out, ovr_out); end
  endtask

  task automatic test_random();
    int start_err;
    int r;
    do_reset();
    start_err = errors;
    for (int cyc = 0; cyc < 3000 && (errors - start_err) < 20; cyc++) begin
      if ($urandom_range(0, 99) < 3) begin
        r = $urandom_range(0, N - 1);
        chan_en_in[r] = ~chan_en_in[r];
      end
      for (int c = 0; c < N; c++) begin
        dv_in[c] = ($urandom_range(0, 99) < 35);
        data_in[c*W +: W] = 18'($urandom);
      end
      r = $urandom_range(0, 99);
      if (r < 4) begin
        wr_en = 1'b1; wr_addr = A_GAP; wr_data = 48'($urandom_range(0, 4));
      end else if (r < 8) begin
        wr_en = 1'b1; wr_addr = A_CLR; wr_data = {16'($urandom), 32'($urandom)};
      end else if (r < 10) begin
        wr_en = 1'b1; wr_addr = 16'($urandom_range(16'h0042, 16'hFFFF)); wr_data = {16'($urandom), 32'($urandom)};
      end
      tick();
      checks++;
      if (dv_out !== exp_dv) begin errors++; $display("FAIL rand_dv: cycle %0d dv=%0b expected %0b", cyc, dv_out, exp_dv); end
      checks++;
      if (chan_out !== 8'(exp_chan)) begin errors++; $display("FAIL rand_chan: cycle %0d chan=%0d expected %0d", cyc, chan_out, exp_chan); end
      checks++;
      if (data_out !== exp_data) begin errors++; $display("FAIL rand_data: cycle %0d data=%h expected %h", cyc, data_out, exp_data); end
      checks++;
      if (ovr_out !== m_ovr) begin errors++; $display("FAIL rand_ovr: cycle %0d ovr=%b expected %b", cyc, ovr_out, m_ovr); end
    end
  endtask

  initial begin
    rst_in     = 1'b1;
    dv_in      = '0;
    data_in    = '0;
    chan_en_in = '1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    test_reset();
    test_single();
    test_gap0();
    test_gap_rewrite();
    test_overrun();
    test_disable();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
